// File: rtl/median5_stream_ctrl_if.sv
// median5_stream_ctrl_if
// Groups the sample-side and filter-side valid/ready handshakes of the
// median5 streaming controller, together with the runtime noise threshold.
//
// Signals:
//   in_data/in_valid/in_last   sample stream from the source
//   in_ready                   controller can take a sample this cycle
//   threshold                  noise threshold, sampled when a window completes
//   out_data/out_median        filtered sample and window median
//   out_noise/out_last         center-sample noise flag, end-of-line marker
//   out_valid/out_ready        result handshake towards the downstream stage
//
// Modports:
//   slave  - the controller's view
//   master - the view of whatever drives samples and consumes results
interface median5_stream_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] threshold;
  logic [DATA_WIDTH-1:0] out_data;
  logic [DATA_WIDTH-1:0] out_median;
  logic                  out_noise;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, in_last, threshold, out_ready,
    output in_ready, out_data, out_median, out_noise, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, threshold, out_ready,
    input  in_ready, out_data, out_median, out_noise, out_last, out_valid
  );
endinterface

// File: rtl/median5_stream_ctrl.sv
// median5_stream_ctrl
// Shifts a sample stream through a 5-deep sliding window, sorts the window
// with a 5-input sorting network (sorter5) and registers the median. The
// window's center sample is flagged as noise when it deviates from the
// median by more than a runtime threshold. Windows never span a line
// boundary: in_last restarts the fill phase.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - median5_stream_ctrl_if.slave (sample input, result output,
//          threshold)
//
// Optional feature macro: NOISE_REPLACE_EN
//   defined   : out_data is the median only for noisy centers, otherwise the
//               unmodified center sample (selective replacement)
//   undefined : out_data always equals out_median (plain median filter)

// sorter5: combinational 9-comparator sorting network, o1..o5 ascending.
module sorter5 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i1,
  input  logic [DATA_WIDTH-1:0] i2,
  input  logic [DATA_WIDTH-1:0] i3,
  input  logic [DATA_WIDTH-1:0] i4,
  input  logic [DATA_WIDTH-1:0] i5,
  output logic [DATA_WIDTH-1:0] o1,
  output logic [DATA_WIDTH-1:0] o2,
  output logic [DATA_WIDTH-1:0] o3,
  output logic [DATA_WIDTH-1:0] o4,
  output logic [DATA_WIDTH-1:0] o5
);
  // Comparator pairs in network order; each swaps so the lower index holds
  // the smaller value.
  localparam int PA [9] = '{0, 3, 2, 2, 1, 0, 0, 1, 1};
  localparam int PB [9] = '{1, 4, 4, 3, 4, 3, 2, 3, 2};

  logic [DATA_WIDTH-1:0] v [5];
  logic [DATA_WIDTH-1:0] t;

  always_comb begin
    t    = '0;
    v[0] = i1;
    v[1] = i2;
    v[2] = i3;
    v[3] = i4;
    v[4] = i5;
    for (int k = 0; k < 9; k++) begin
      if (v[PA[k]] > v[PB[k]]) begin
        t        = v[PA[k]];
        v[PA[k]] = v[PB[k]];
        v[PB[k]] = t;
      end
    end
  end

  assign o1 = v[0];
  assign o2 = v[1];
  assign o3 = v[2];
  assign o4 = v[3];
  assign o5 = v[4];
endmodule

module median5_stream_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  median5_stream_ctrl_if.slave  bus
);
  typedef enum logic {FILL, RUN} state_t;

  state_t                state;
  logic [2:0]            cnt;
  logic [DATA_WIDTH-1:0] w0, w1, w2, w3, w4;
  logic [DATA_WIDTH-1:0] out_data_q, out_median_q;
  logic                  out_noise_q, out_last_q, out_valid_q;

  logic                  accept;
  logic                  produce;
  logic [DATA_WIDTH-1:0] s1, s2, s3, s4, s5;
  logic [DATA_WIDTH:0]   center_x, median_x, diff;
  logic                  noise;
  logic [DATA_WIDTH-1:0] data_sel;

  // A new sample may enter whenever the output register is free or is
  // being drained this same cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign produce      = accept && ((state == RUN) || (cnt == 3'd4));

  // The sorter sees the window as it will be after this cycle's shift, so
  // the result registered on the accept edge belongs to the new window.
  sorter5 #(.DATA_WIDTH(DATA_WIDTH)) u_sorter (
    .i1(w1), .i2(w2), .i3(w3), .i4(w4), .i5(bus.in_data),
    .o1(s1), .o2(s2), .o3(s3), .o4(s4), .o5(s5)
  );

  // w3 becomes the new center after the shift. The deviation is taken one
  // bit wider so the subtraction can never wrap.
  assign center_x = {1'b0, w3};
  assign median_x = {1'b0, s3};
  assign diff     = (center_x >= median_x) ? (center_x - median_x)
                                           : (median_x - center_x);
  assign noise    = diff > {1'b0, bus.threshold};

`ifdef NOISE_REPLACE_EN
  assign data_sel = noise ? s3 : w3;
`else
  assign data_sel = s3;
`endif

  // w0 and the outer sorter outputs are kept for window/debug visibility
  // but do not feed any result.
  logic unused_window;
  assign unused_window = ^{w0, s1, s2, s4, s5};

  // Fill/run sequencing, window shift and registered result stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      cnt          <= '0;
      w0           <= '0;
      w1           <= '0;
      w2           <= '0;
      w3           <= '0;
      w4           <= '0;
      out_data_q   <= '0;
      out_median_q <= '0;
      out_noise_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      if (accept) begin
        w0 <= w1;
        w1 <= w2;
        w2 <= w3;
        w3 <= w4;
        w4 <= bus.in_data;
        if (bus.in_last) begin
          state <= FILL;
          cnt   <= '0;
        end else if (state == FILL) begin
          if (cnt == 3'd4) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
      end

      if (produce) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= data_sel;
        out_median_q <= s3;
        out_noise_q  <= noise;
        out_last_q   <= bus.in_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_median = out_median_q;
  assign bus.out_noise  = out_noise_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;
endmodule

// File: tb/tb_median5_stream_ctrl.sv
// tb_median5_stream_ctrl
// Scoreboard bench for median5_stream_ctrl. Accepted samples are fed to a
// line-based reference model (sort the last five samples of the current
// line) that queues expected results; an independent monitor pops and
// compares on every output transfer. Directed sequences cover fill, line
// ends, backpressure, mid-run reset and threshold edges, followed by a
// randomized stream with random downstream stalls.
module tb_median5_stream_ctrl;
  typedef struct {
    logic [7:0] data;
    logic [7:0] median;
    logic       noise;
    logic       last;
  } exp_t;

  logic clk;
  logic rst;
  logic rand_ready;

  int checks;
  int errors;
  int out_count;
  int last_count;

  exp_t exp_q [$];
  int   line_q [$];

  logic       hold_prev;
  logic [7:0] snap_data, snap_median;
  logic       snap_noise, snap_last;

  median5_stream_ctrl_if #(.DATA_WIDTH(8)) bus ();

  median5_stream_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Random downstream stalls during the randomized phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: results depend only on the last five samples of the
  // current line and on the threshold at the moment the fifth arrives.
  always @(negedge clk) begin
    int   sorted [$];
    int   med, ctr, dev;
    exp_t e;
    if (rst) begin
      line_q.delete();
      exp_q.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      line_q.push_back(int'(bus.in_data));
      if (line_q.size() > 5) void'(line_q.pop_front());
      if (line_q.size() == 5) begin
        sorted = line_q;
        sorted.sort();
        med = sorted[2];
        ctr = line_q[2];
        dev = (ctr > med) ? ctr - med : med - ctr;
        e.median = 8'(med);
        e.noise  = dev > int'(bus.threshold);
`ifdef NOISE_REPLACE_EN
        e.data   = e.noise ? 8'(med) : 8'(ctr);
`else
        e.data   = 8'(med);
`endif
        e.last   = bus.in_last;
        exp_q.push_back(e);
      end
      if (bus.in_last) line_q.delete();
    end
  end

  // Monitor: compares every output transfer against the scoreboard and
  // checks that a stalled output does not move.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checkOutput("hold_valid", int'(bus.out_valid), 1);
        checkOutput("hold_data", int'(bus.out_data), int'(snap_data));
        checkOutput("hold_median", int'(bus.out_median), int'(snap_median));
        checkOutput("hold_flags", int'({bus.out_noise, bus.out_last}),
                    int'({snap_noise, snap_last}));
      end
      if (bus.out_valid && bus.out_ready) begin
        out_count++;
        if (bus.out_last) last_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got data %0d expected no output at %0t",
                   bus.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data", int'(bus.out_data), int'(e.data));
          checkOutput("out_median", int'(bus.out_median), int'(e.median));
          checkOutput("out_noise", int'(bus.out_noise), int'(e.noise));
          checkOutput("out_last", int'(bus.out_last), int'(e.last));
        end
      end
      hold_prev   = bus.out_valid && !bus.out_ready;
      snap_data   = bus.out_data;
      snap_median = bus.out_median;
      snap_noise  = bus.out_noise;
      snap_last   = bus.out_last;
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic l, input logic [7:0] thr);
    int guard;
    guard         = 0;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.threshold = thr;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitOutput(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(name, int'(bus.out_valid), 1);
  endtask

  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    @(posedge clk);
    #2;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_valid"}, int'(bus.out_valid), 0);
    checkOutput({name, "_data"}, int'(bus.out_data), 0);
    checkOutput({name, "_median"}, int'(bus.out_median), 0);
    checkOutput({name, "_flags"}, int'({bus.out_noise, bus.out_last}), 0);
    checkOutput({name, "_in_ready"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int         base_out, base_last;
    logic [7:0] line_a [5];
    logic [7:0] line_b [5];
    logic [7:0] edge_w [5];

    clk           = 1'b0;
    rst           = 1'b1;
    rand_ready    = 1'b0;
    checks        = 0;
    errors        = 0;
    out_count     = 0;
    last_count    = 0;
    hold_prev     = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.threshold = '0;
    bus.out_ready = 1'b1;
    line_a = '{8'd10, 8'd20, 8'd200, 8'd30, 8'd40};
    line_b = '{8'd10, 8'd50, 8'd20, 8'd40, 8'd30};
    edge_w = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkReset("reset");

    // Fill and flag: no output until the fifth sample completes the window.
    for (int i = 0; i < 4; i++) applyStimulus(line_a[i], 1'b0, 8'd50);
    checkOutput("fill_no_output", int'(bus.out_valid), 0);
    applyStimulus(line_a[4], 1'b1, 8'd50);
    checkOutput("fill_latency", int'(bus.out_valid), 1);
    checkOutput("fill_median", int'(bus.out_median), 30);
    checkOutput("fill_noise", int'(bus.out_noise), 1);
    checkOutput("fill_data", int'(bus.out_data), 30);
    waitDrain("fill_drain");

    // Replace versus median: quiet center.
    for (int i = 0; i < 5; i++) applyStimulus(line_b[i], i == 4, 8'd50);
    waitOutput("repl_valid");
    checkOutput("repl_median", int'(bus.out_median), 30);
    checkOutput("repl_noise", int'(bus.out_noise), 0);
`ifdef NOISE_REPLACE_EN
    checkOutput("repl_data", int'(bus.out_data), 20);
`else
    checkOutput("repl_data", int'(bus.out_data), 30);
`endif
    waitDrain("repl_drain");

    // Backpressure in RUN: three stalled cycles with a sample waiting.
    for (int i = 0; i < 6; i++) applyStimulus(8'(17 * i + 5), 1'b0, 8'd20);
    bus.out_ready = 1'b0;
    fork
      applyStimulus(8'd99, 1'b0, 8'd20);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    applyStimulus(8'd3, 1'b1, 8'd20);
    waitDrain("bp_drain");

    // Line end: 7-sample line gives 3 outputs, 3-sample line gives none.
    base_out  = out_count;
    base_last = last_count;
    for (int i = 0; i < 7; i++) applyStimulus(8'(i * 31 + 2), i == 6, 8'd10);
    for (int i = 0; i < 3; i++) applyStimulus(8'(i * 7 + 90), i == 2, 8'd10);
    waitDrain("line_drain");
    checkOutput("line_outputs", out_count - base_out, 3);
    checkOutput("line_last_count", last_count - base_last, 1);

    // Reset while an output is pending.
    for (int i = 0; i < 5; i++) applyStimulus(8'(i * 40 + 1), 1'b0, 8'd30);
    bus.out_ready = 1'b0;
    checkOutput("rst_pending", int'(bus.out_valid), 1);
    applyReset();
    checkReset("midreset");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(8'(i * 9 + 60), 1'b0, 8'd30);
    checkOutput("rst_refill_none", int'(bus.out_valid), 0);
    applyStimulus(8'd200, 1'b1, 8'd30);
    checkOutput("rst_refill_out", int'(bus.out_valid), 1);
    waitDrain("rst_drain");

    // Threshold edges: deviation 255 against 255 and 254.
    for (int i = 0; i < 5; i++) applyStimulus(edge_w[i], i == 4, 8'd255);
    waitOutput("thr255_valid");
    checkOutput("thr255_noise", int'(bus.out_noise), 0);
    waitDrain("thr255_drain");
    for (int i = 0; i < 5; i++) applyStimulus(edge_w[i], i == 4, 8'd254);
    waitOutput("thr254_valid");
    checkOutput("thr254_noise", int'(bus.out_noise), 1);
    waitDrain("thr254_drain");

    // Randomized stream with idle gaps, random line ends and stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] thr;
      case ($urandom_range(0, 5))
        0:       thr = 8'd0;
        1:       thr = 8'd255;
        default: thr = 8'($urandom_range(0, 90));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0, thr);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    waitDrain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
